serial_adder: RTL
=================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning operand/result width in bits (legal range 1..32).
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset (one clock; reset is synchronous and active-high).
REQ-004 SHALL have port start, input, 1, request to begin an operation, sampled on rising edge of clk.
REQ-005 SHALL have port a, input, WIDTH, first operand, sampled with start.
REQ-006 SHALL have port b, input, WIDTH, second operand, sampled with start.
REQ-007 SHALL have port c_in, input, 1, carry-in, sampled with start; ignored when sub=1.
REQ-008 SHALL have port sub, input, 1, mode select sampled with start: 0 = a+b+c_in, 1 = a-b.
REQ-009 SHALL have port busy, output, 1, high while bits are being processed.
REQ-010 SHALL have port done, output, 1, single-cycle pulse when result becomes valid.
REQ-011 SHALL have port z, output, WIDTH, sum/difference.
REQ-012 SHALL have port c_out, output, 1, carry out of MSB (for sub: 1 = no borrow).
REQ-013 SHALL have port ovf, output, 1, two's-complement overflow flag.

Function
REQ-014 SHALL implement FSM with states IDLE, RUN, DONE.
REQ-015 IDLE: start=1 at an edge latches a, b (bitwise inverted if sub=1), carry register = (sub ? 1 : c_in), bit counter = 0; next state RUN.
REQ-016 RUN: each cycle SHALL process exactly one bit, LSB first, with one full-adder cell: sum bit = a_i ^ b_i ^ carry, carry' = a_i&b_i | carry&(a_i^b_i).
REQ-017 RUN SHALL last exactly WIDTH cycles; busy=1 in every RUN cycle, 0 otherwise.
REQ-018 After the last RUN cycle, state SHALL be DONE for exactly one cycle with done=1.
REQ-019 z, c_out, ovf SHALL update together on entry to DONE and hold until the next accepted start's DONE or reset; intermediate RUN values SHALL NOT appear on z.
REQ-020 ovf SHALL equal carry into MSB XOR carry out of MSB; for WIDTH=1, carry into MSB is the initial carry.
REQ-021 Latency: start sampled at edge T -> busy high cycles T+1..T+WIDTH -> done high in cycle T+WIDTH+1.
REQ-022 start while in RUN SHALL be ignored; operands not re-latched.
REQ-023 start=1 in DONE SHALL be accepted (DONE -> RUN directly, back-to-back ops, no IDLE gap); otherwise DONE -> IDLE.
REQ-024 Result SHALL match (a + b + c_in) mod 2^(WIDTH+1) split as {c_out, z}, or a + ~b + 1 for sub.

Reset
REQ-025 reset=1 at an edge SHALL force IDLE, busy=0, done=0, z=0, c_out=0, ovf=0, counter=0, carry=0.
REQ-026 reset SHALL take priority over start and abort any RUN in progress; no done pulse for aborted op.
REQ-027 start concurrent with reset SHALL be dropped.

Verification (WIDTH=8 unless noted)
REQ-028 a=0x0F, b=0x01, c_in=0, sub=0 -> busy high 8 cycles, then done=1, z=0x10, c_out=0, ovf=0.
REQ-029 a=0xFF, b=0x01, c_in=0 -> z=0x00, c_out=1, ovf=0; a=0x7F, b=0x00, c_in=1 -> z=0x80, c_out=0, ovf=1.
REQ-030 sub=1, a=0x05, b=0x07, c_in=1 -> z=0xFE, c_out=0, ovf=0; a=0x80, b=0x01 -> z=0x7F, c_out=1, ovf=1.
REQ-031 reset asserted in 3rd busy cycle -> next cycle busy=0, z=0x00, no done; start with new operands then completes normally.
REQ-032 start held high across RUN -> operands latched once; start high during DONE -> second op begins, busy next cycle, done exactly 9 cycles after first done.
REQ-033 WIDTH=1: all 8 combinations of a, b, c_in -> {c_out, z} == a+b+c_in after 1 busy cycle; every combination must pass.

Source files
------------

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder cell, LSB first, WIDTH cycles per op.
// Result registers update only on entry to DONE and hold until the next result.
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] z,
  output logic             c_out,
  output logic             ovf
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [WIDTH-1:0] z_q, z_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             c_out_q, c_out_d;
  logic             ovf_q, ovf_d;

  logic a_bit, b_bit, sum_bit, carry_nx;

  always_comb begin
    a_bit    = a_q[cnt_q];
    b_bit    = b_q[cnt_q];
    sum_bit  = a_bit ^ b_bit ^ carry_q;
    carry_nx = (a_bit & b_bit) | (carry_q & (a_bit ^ b_bit));

    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    z_d     = z_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    c_out_d = c_out_q;
    ovf_d   = ovf_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          // subtraction is a + ~b + 1, so invert b and force the initial carry
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub | c_in;
          cnt_d   = '0;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        sum_d[cnt_q] = sum_bit;
        carry_d      = carry_nx;
        if (cnt_q == LAST) begin
          // carry_q here is the carry into the MSB cell
          z_d     = sum_d;
          c_out_d = carry_nx;
          ovf_d   = carry_q ^ carry_nx;
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      z_q     <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      z_q     <= z_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      c_out_q <= c_out_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy  = (state_q == S_RUN);
  assign done  = (state_q == S_DONE);
  assign z     = z_q;
  assign c_out = c_out_q;
  assign ovf   = ovf_q;

endmodule
